// File: rtl/avst_pkg.sv
// Shared Avalon-ST constants and helpers for the byte-stream to wide-bus path.
// Pure declarations; no logic, no latency, no flow control.
package avst_pkg;

   localparam int AVST_BYTE_W    = 8;
   localparam int AVST_DEF_BYTES = 4;

   // Width of an empty-lane count for a word of 'bytes' lanes.
   function automatic int avst_empty_w(input int bytes);
      return (bytes < 2) ? 1 : $clog2(bytes);
   endfunction

endpackage

// File: rtl/avst_byte_packer.sv
// Packs an 8-bit Avalon-ST stream into BYTES-wide words; completing byte appears on the output one edge after acceptance.
// One extra word is parked in the accumulator under backpressure; ready_in is registered and drops only when that slot is taken.
module avst_byte_packer
   import avst_pkg::*;
#(
   parameter int BYTES = AVST_DEF_BYTES,
   parameter int EW    = avst_empty_w(BYTES)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [AVST_BYTE_W-1:0]       data_in,
   input  logic                         end_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   output logic [AVST_BYTE_W*BYTES-1:0] data_out,
   output logic [EW-1:0]                empty_out,
   output logic                         end_out,
   output logic                         valid_out,
   input  logic                         ready_out
);

   typedef logic [BYTES-1:0][AVST_BYTE_W-1:0] word_t;

   localparam logic [EW-1:0] LANE_LAST = EW'(BYTES - 1);

   word_t         acc;
   logic [EW-1:0] lane;
   logic          acc_full;
   logic [EW-1:0] acc_empty;
   logic          acc_end;

   logic          accept;
   logic          drain;
   logic          complete;
   word_t         word;
   logic [EW-1:0] word_empty;

   // Bytes already collected plus the incoming one; lanes above it are zero.
   always_comb begin
      accept     = valid_in && ready_in;
      drain      = !valid_out || ready_out;
      complete   = accept && (end_in || (lane == LANE_LAST));
      word       = '0;
      word_empty = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (i < int'(lane))
            word[i] = acc[i];
         else if (i == int'(lane))
            word[i] = data_in;
      end
      if (end_in)
         word_empty = LANE_LAST - lane;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= '0;
         lane      <= '0;
         acc_full  <= 1'b0;
         acc_empty <= '0;
         acc_end   <= 1'b0;
         data_out  <= '0;
         empty_out <= '0;
         end_out   <= 1'b0;
         valid_out <= 1'b0;
         ready_in  <= 1'b0;
      end else if (acc_full) begin
         // Parked word leaves as soon as the output slot frees up.
         if (drain) begin
            data_out  <= acc;
            empty_out <= acc_empty;
            end_out   <= acc_end;
            valid_out <= 1'b1;
            acc_full  <= 1'b0;
            lane      <= '0;
            ready_in  <= 1'b1;
         end else begin
            ready_in  <= 1'b0;
         end
      end else if (complete) begin
         lane <= '0;
         if (drain) begin
            data_out  <= word;
            empty_out <= word_empty;
            end_out   <= end_in;
            valid_out <= 1'b1;
            ready_in  <= 1'b1;
         end else begin
            acc       <= word;
            acc_empty <= word_empty;
            acc_end   <= end_in;
            acc_full  <= 1'b1;
            ready_in  <= 1'b0;
         end
      end else begin
         if (accept) begin
            acc[lane] <= data_in;
            lane      <= lane + EW'(1);
         end
         if (ready_out)
            valid_out <= 1'b0;
         ready_in <= 1'b1;
      end
   end

endmodule

// File: doc/avst_byte_packer.md
# avst_byte_packer

Downstream stage of `adder_avst`: consumes its 8-bit Avalon-ST output stream (data/valid/end, ready backpressure) and packs consecutive bytes into `BYTES`-wide words for the wide-bus sink. A packet boundary (`end_in`) always closes the current word, and the unused lane count is reported on `empty_out`. Full input throughput, with no combinational path from `ready_out` to `ready_in`.

## Interface
- `BYTES`, 4: bytes per output word; must be ≥ 2.
- `EW`, `$clog2(BYTES)`: width of `empty_out`; derived, never overridden.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte from `adder_avst`.
- `end_in`  in  1  last byte of packet; qualified by `valid_in`.
- `valid_in`  in  1  input beat valid.
- `ready_in`  out  1  block can accept a byte; registered.
- `data_out`  out  8*BYTES  packed word, first byte in bits [7:0].
- `empty_out`  out  EW  unused lanes in the word; nonzero only with `end_out`.
- `end_out`  out  1  word closes a packet.
- `valid_out`  out  1  output beat valid.
- `ready_out`  in  1  sink accepts the word.

## Operation
- Input beat accepted when `valid_in && ready_in`. Output beat transferred when `valid_out && ready_out`.
- Datapath:
  - accumulator `acc` (BYTES lanes), lane counter `lane` (0..BYTES-1), flag `acc_full`;
  - output register (`data_out`, `empty_out`, `end_out`, `valid_out`).
- Accepted byte written to lane `lane`. The word is complete when `lane == BYTES-1` or `end_in == 1`.
- Complete word, `k = lane+1` bytes filled:
  - lanes ≥ k zeroed;
  - `empty = end_in ? BYTES-k : 0`; `end = end_in`.
- Completion routing:
  - Output register free (`!valid_out`) or draining (`ready_out`) in the same cycle: load the output register directly, `lane ← 0`.
  - Otherwise: set `acc_full`, hold the word in `acc`.
- State HOLD (`acc_full == 1`):
  - `ready_in = 0`;
  - when the output register is free or draining, `acc` moves into it, `acc_full ← 0`, `lane ← 0`.
- `ready_in` is registered: `ready_in_next = !acc_full_next`.
- Output register holds steady while `valid_out && !ready_out`. `valid_out` falls after transfer unless it is reloaded in the same cycle.
- A single-byte packet (`end_in` at lane 0) produces one word with `empty_out = BYTES-1`.
- `end_in` on lane `BYTES-1` produces `empty_out = 0`, `end_out = 1`.
- X on `data_in` / `end_in` while `valid_in == 0` is ignored and never propagates to registers.

## Timing
- Reset (asynchronous assert, `reset_n == 0`):
  - `ready_in = 0`, `valid_out = 0`, `end_out = 0`, `empty_out = 0`, `data_out = 0`;
  - `lane = 0`, `acc_full = 0`, `acc = 0`.
- `ready_in` rises on the first `clk` rising edge after `reset_n` deasserts.
- Latency: the completing byte accepted at edge N produces `valid_out` high after edge N with the packed word, provided the output register was free or draining.
- Throughput: one byte per cycle sustained while `ready_out == 1`; `BYTES` input beats per output beat.
- Backpressure: with `ready_out == 0`, at most one further word is buffered in `acc`. After that, `ready_in` drops the cycle after completion.
- Reset mid-packet discards the partial word and any held or output word. No `end_out` is emitted for the discarded packet.
- Simultaneous events in HOLD: `ready_out` high empties the output register and loads `acc` on the same edge; `ready_in` returns one cycle later.

## Structure
- Shared package `avst_pkg`:
  - `AVST_BYTE_W = 8`;
  - `AVST_DEF_BYTES = 4`;
  - function `avst_empty_w(bytes)`.
- Packing logic and the output register live in one module. No sub-module: the single-entry output stage is too small to justify splitting out.

## Test plan
- Reset: hold `reset_n = 0` for 5 cycles with `valid_in = 1` → `ready_in = 0`, `valid_out = 0`, all outputs 0. `ready_in = 1` one edge after release.
- Full words: stream 8 bytes `01..08`, `end_in` on `08`, `ready_out = 1` →
  - word 1: `data_out = 32'h04030201`, `end_out = 0`;
  - word 2: `32'h08070605`, `end_out = 1`, `empty_out = 0`;
  - sustained 1 byte/cycle.
- Short packet: bytes `AA`, `BB`, `CC` with `end_in` on `CC` → `data_out = 32'h00CCBBAA`, `empty_out = 1`, `end_out = 1`. Single byte `5A` with end → `32'h0000005A`, `empty_out = 3`.
- Backpressure: `ready_out = 0` while streaming 12 bytes →
  - 2 words accepted, then `ready_in = 0` after byte 8;
  - release `ready_out` → words emitted in order, no loss or duplication, `ready_in` back after one cycle.
- Random: random `valid_in` gaps with delays 0–5, random `ready_out`, 200 packets of length 1–17 → scoreboard reassembles bytes using `empty_out` / `end_out` and matches the input.
- Reset mid-packet: assert `reset_n` after 2 bytes of a packet → no output word; the next packet `11..14` with end emits `32'h14131211`, `end_out = 1`.
